// File: rtl/alu_decoder_seq.sv
// Registered ALU control decoder with a fixed-latency sequencer
// for the multi-cycle CNN ops (conv2d, winograd, pruned winograd).
module alu_decoder_seq #(
   parameter int CTRL_W    = 4,
   parameter int CONV_LAT  = 9,
   parameter int WINO_LAT  = 4,
   parameter int PWINO_LAT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic              flush_i,
   input  logic [1:0]        ALUOp,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic [6:0]        op,
   output logic [CTRL_W-1:0] ALUControl,
   output logic              ctrl_valid,
   output logic              multi_o,
   output logic              conv_start,
   output logic              busy_o,
   output logic              conv_done
);

   localparam int MAX_A   = (CONV_LAT > WINO_LAT) ? CONV_LAT : WINO_LAT;
   localparam int MAX_LAT = (MAX_A > PWINO_LAT) ? MAX_A : PWINO_LAT;
   localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;

   logic [3:0]       dec_code;
   logic             dec_multi;
   logic [CNT_W-1:0] dec_cnt;
   logic             accept;

   // only bit 5 of funct7/op takes part in decoding
   logic unused_bits;
   assign unused_bits = ^{funct7[6], funct7[4:0], op[6], op[4:0]};

   assign accept = valid_i & ~flush_i & (state != RUN);

   // combinational decode of the incoming instruction
   always_comb begin
      dec_code  = 4'b0000;
      dec_multi = 1'b0;
      dec_cnt   = '0;
      case (ALUOp)
         2'b00: dec_code = 4'b0000;
         2'b01: dec_code = 4'b0001;
         2'b11: dec_code = 4'b0100;
         default: begin
            case (funct3)
               3'b001: begin
                  dec_code  = 4'b0111;
                  dec_multi = 1'b1;
                  dec_cnt   = CNT_W'(CONV_LAT - 1);
               end
               3'b011: begin
                  dec_code  = 4'b0110;
                  dec_multi = 1'b1;
                  dec_cnt   = CNT_W'(WINO_LAT - 1);
               end
               3'b000: begin
                  if ({op[5], funct7[5]} == 2'b11)
                     dec_code = 4'b0001;
                  else
                     dec_code = 4'b0000;
               end
               3'b010: begin
                  dec_code  = 4'b0101;
                  dec_multi = 1'b1;
                  dec_cnt   = CNT_W'(PWINO_LAT - 1);
               end
               3'b110: dec_code = 4'b0011;
               3'b111: dec_code = 4'b0010;
               3'b100: dec_code = 4'b1000;
               3'b101: begin
                  if (funct7[5])
                     dec_code = 4'b1010;
                  else
                     dec_code = 4'b1001;
               end
               default: dec_code = 4'b0000;
            endcase
         end
      endcase
   end

   // sequencer: issue, count down the op latency, pulse done
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         ALUControl <= '0;
         ctrl_valid <= 1'b0;
         multi_o    <= 1'b0;
         conv_start <= 1'b0;
         busy_o     <= 1'b0;
         conv_done  <= 1'b0;
      end else begin
         ctrl_valid <= 1'b0;
         conv_start <= 1'b0;
         conv_done  <= 1'b0;
         if (flush_i) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_o <= 1'b0;
         end else begin
            case (state)
               RUN: begin
                  if (cnt == CNT_W'(1)) begin
                     state     <= DONE;
                     cnt       <= '0;
                     busy_o    <= 1'b0;
                     conv_done <= 1'b1;
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
               default: begin
                  if (accept) begin
                     ALUControl <= CTRL_W'(dec_code);
                     multi_o    <= dec_multi;
                     ctrl_valid <= 1'b1;
                     if (dec_multi) begin
                        state      <= RUN;
                        cnt        <= dec_cnt;
                        conv_start <= 1'b1;
                        busy_o     <= 1'b1;
                     end else begin
                        state  <= IDLE;
                        cnt    <= '0;
                        busy_o <= 1'b0;
                     end
                  end else begin
                     state  <= IDLE;
                     cnt    <= '0;
                     busy_o <= 1'b0;
                  end
               end
            endcase
         end
      end
   end

endmodule
